mem_port_arbiter: RTL

//  Shares one single-port synchronous RAM between the instruction-fetch requester (IF) and the

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter_prio.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 78 +++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/LS memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH_DEF    = 32;
    localparam int unsigned DATA_WIDTH_DEF    = 32;
    localparam int unsigned RAM_AW_DEF        = 10;
    localparam int unsigned MAX_LS_STREAK_DEF = 4;

    // Which requester owns the RAM access issued in the previous cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_LS   = 2'b10
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and RAM-side signal bundle of the memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RAM_AW     = 10
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic                  if_req_valid;
    logic [ADDR_WIDTH-1:0] if_req_addr;
    logic                  if_req_ready;
    logic                  if_rsp_valid;
    logic [DATA_WIDTH-1:0] if_rsp_rdata;

    logic                  ls_req_valid;
    logic                  ls_req_we;
    logic [ADDR_WIDTH-1:0] ls_req_addr;
    logic [STRB_W-1:0]     ls_req_wstrb;
    logic [DATA_WIDTH-1:0] ls_req_wdata;
    logic                  ls_req_ready;
    logic                  ls_rsp_valid;
    logic [DATA_WIDTH-1:0] ls_rsp_rdata;

    logic                  ram_en;
    logic [STRB_W-1:0]     ram_we;
    logic [RAM_AW-1:0]     ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_rdata,
        input  ls_req_valid, ls_req_we, ls_req_addr, ls_req_wstrb, ls_req_wdata,
        output ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata,
        output ls_req_valid, ls_req_we, ls_req_addr, ls_req_wstrb, ls_req_wdata,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// LS-priority grant decision with a streak counter that bounds IF starvation.
module mem_arb_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_LS_STREAK = MAX_LS_STREAK_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic if_valid,
    input  logic ls_valid,
    output logic grant_if,
    output logic grant_ls
);
    localparam int unsigned          STREAK_W   = $clog2(MAX_LS_STREAK + 1);
    localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;

    // Grants are masked during reset so no RAM access (and no write) can issue
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        streak_d = '0;
        if (!rst) begin
            grant_if = if_valid && (!ls_valid || (streak_q == STREAK_MAX));
            grant_ls = ls_valid && !grant_if;
        end
        if (grant_ls && if_valid) begin
            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between IF and LS requesters; read data
// returns one cycle after issue and is steered to the issuing requester.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int unsigned RAM_AW        = RAM_AW_DEF,
    parameter int unsigned MAX_LS_STREAK = MAX_LS_STREAK_DEF
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic   grant_if, grant_ls;
    owner_e owner_q, owner_d;
    logic   we_q, we_d;
    logic   unused_addr_bits;

    mem_arb_prio #(
        .MAX_LS_STREAK (MAX_LS_STREAK)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .if_valid (bus.if_req_valid),
        .ls_valid (bus.ls_req_valid),
        .grant_if (grant_if),
        .grant_ls (grant_ls)
    );

    // Byte offset and bits above the RAM window do not select a word
    assign unused_addr_bits = ^{bus.if_req_addr[1:0], bus.if_req_addr[ADDR_WIDTH-1:RAM_AW+2],
                                bus.ls_req_addr[1:0], bus.ls_req_addr[ADDR_WIDTH-1:RAM_AW+2]};

    // Issue mux and response tag for the access granted this cycle
    always_comb begin
        bus.if_req_ready = grant_if;
        bus.ls_req_ready = grant_ls;
        bus.ram_en       = 1'b0;
        bus.ram_we       = '0;
        bus.ram_addr     = '0;
        bus.ram_wdata    = bus.ls_req_wdata;
        owner_d          = OWN_NONE;
        we_d             = 1'b0;
        if (grant_if) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = bus.if_req_addr[RAM_AW+1:2];
            owner_d      = OWN_IF;
        end else if (grant_ls) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = bus.ls_req_addr[RAM_AW+1:2];
            bus.ram_we   = bus.ls_req_we ? bus.ls_req_wstrb : STRB_W'(0);
            owner_d      = OWN_LS;
            we_d         = bus.ls_req_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            we_q    <= 1'b0;
        end else begin
            owner_q <= owner_d;
            we_q    <= we_d;
        end
    end

    // Write acks carry zero data so LS never sees stale RAM output
    always_comb begin
        bus.if_rsp_valid = (owner_q == OWN_IF);
        bus.ls_rsp_valid = (owner_q == OWN_LS);
        bus.if_rsp_rdata = bus.if_rsp_valid ? bus.ram_rdata : DATA_WIDTH'(0);
        bus.ls_rsp_rdata = (bus.ls_rsp_valid && !we_q) ? bus.ram_rdata : DATA_WIDTH'(0);
    end

endmodule
